truth_table_scanner: RTL and testbench

//  Sequential stage that sits directly upstream of a 4-input combinational function block.
//  On start it drives the function inputs (a,b,c,d) through all 2**N_IN vectors in order,

---
 rtl/truth_table_scanner_pkg.sv | 21 ++
 rtl/truth_table_scanner_if.sv | 23 ++
 rtl/truth_table_scanner_settle_timer.sv | 30 +++
 rtl/truth_table_scanner.sv | 123 ++++++++++++
 tb/tb_truth_table_scanner.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/truth_table_scanner_pkg.sv
// Shared types and constants for the truth-table scanner: FSM encoding and
// the mapping of function inputs onto the scan vector.
package truth_table_scanner_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_FINISH = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    SETTLE = ST_SETTLE,
    FINISH = ST_FINISH
  } state_e;

  // Position of each function input inside vec.
  localparam int unsigned A_BIT = 3;
  localparam int unsigned B_BIT = 2;
  localparam int unsigned C_BIT = 1;
  localparam int unsigned D_BIT = 0;

endpackage

// File: rtl/truth_table_scanner_if.sv
// Handshake and result bus between the scanner and its requester/function block.
interface truth_table_scanner_if #(
  parameter int unsigned N_IN = 4
);
  logic                 start;
  logic [N_IN-1:0]      vec;
  logic                 s_in;
  logic                 busy;
  logic                 done;
  logic [2**N_IN-1:0]   table_o;
  logic [N_IN:0]        ones_cnt;
  logic                 table_valid;

  modport master (
    output start, s_in,
    input  vec, busy, done, table_o, ones_cnt, table_valid
  );

  modport slave (
    input  start, s_in,
    output vec, busy, done, table_o, ones_cnt, table_valid
  );
endinterface

// File: rtl/truth_table_scanner_settle_timer.sv
// Loadable down-counter that measures the settle time of each applied vector.
module truth_table_scanner_settle_timer #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic dec,
  output logic zero_c
);

  localparam int unsigned CW = $clog2(SETTLE_CYCLES) + 1;
  localparam logic [CW-1:0] LOAD_VAL = CW'(SETTLE_CYCLES - 1);

  logic [CW-1:0] cnt_q;

  // Load has priority; decrement saturates at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= LOAD_VAL;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

  assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/truth_table_scanner.sv
// Walks a combinational function through every input vector, samples its output
// into a truth-table word and counts the minterms, with a busy/done handshake.
module truth_table_scanner
  import truth_table_scanner_pkg::*;
#(
  parameter int unsigned N_IN          = 4,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  truth_table_scanner_if.slave  bus
);

  localparam int unsigned TW = 2**N_IN;
  localparam int unsigned CW = N_IN + 1;
  localparam logic [N_IN-1:0] LAST_VEC = N_IN'(TW - 1);

  state_e          state_q, state_d;
  logic [N_IN-1:0] vec_q, vec_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            valid_q, valid_d;
  logic [TW-1:0]   table_q, table_d;
  logic [CW-1:0]   ones_q, ones_d;

  logic tmr_load_c;
  logic tmr_dec_c;
  logic tmr_zero_c;

  truth_table_scanner_settle_timer #(
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) u_settle_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (tmr_load_c),
    .dec    (tmr_dec_c),
    .zero_c (tmr_zero_c)
  );

  // State and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      vec_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      table_q <= '0;
      ones_q  <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      valid_q <= valid_d;
      table_q <= table_d;
      ones_q  <= ones_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    vec_d      = vec_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    valid_d    = valid_q;
    table_d    = table_q;
    ones_d     = ones_q;
    tmr_load_c = 1'b0;
    tmr_dec_c  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d    = SETTLE;
          vec_d      = '0;
          busy_d     = 1'b1;
          valid_d    = 1'b0;
          table_d    = '0;
          ones_d     = '0;
          tmr_load_c = 1'b1;
        end
      end

      SETTLE: begin
        if (!tmr_zero_c) begin
          tmr_dec_c = 1'b1;
        end else begin
          // Sample edge: capture s_in for the vector currently applied.
          table_d[vec_q] = bus.s_in;
          ones_d         = ones_q + CW'(bus.s_in);
          if (vec_q == LAST_VEC) begin
            state_d = FINISH;
            vec_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            valid_d = 1'b1;
          end else begin
            vec_d      = vec_q + N_IN'(1);
            tmr_load_c = 1'b1;
          end
        end
      end

      FINISH: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.vec         = vec_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.table_o     = table_q;
  assign bus.ones_cnt    = ones_q;
  assign bus.table_valid = valid_q;

endmodule

// File: tb/tb_truth_table_scanner.sv
// Directed bench for truth_table_scanner: expected tables are queued at start and
// checked when done pulses, alongside handshake timing and reset behaviour.
module tb_truth_table_scanner;
  import truth_table_scanner_pkg::*;

  typedef struct packed {
    logic [15:0] tab;
    logic [4:0]  ones;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] s_mode;   // 0: function block, 1: tied high, 2: tied low
  int         n_checks = 0;
  int         n_fails  = 0;
  exp_t       sb_q[$];

  truth_table_scanner_if #(.N_IN(4)) bus1 ();
  truth_table_scanner_if #(.N_IN(4)) bus3 ();

  truth_table_scanner #(.N_IN(4), .SETTLE_CYCLES(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1.slave)
  );

  truth_table_scanner #(.N_IN(4), .SETTLE_CYCLES(3)) u_dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus3.slave)
  );

  always #5 clk = ~clk;

  // Reference function block: s = ~b&c | ~a&b&~c | a&b&d.
  function automatic logic func_s(input logic [3:0] v);
    logic a, b, c, d;
    a = v[A_BIT];
    b = v[B_BIT];
    c = v[C_BIT];
    d = v[D_BIT];
    return (~b & c) | (~a & b & ~c) | (a & b & d);
  endfunction

  assign bus1.s_in = (s_mode == 2'd1) ? 1'b1 : (s_mode == 2'd2) ? 1'b0 : func_s(bus1.vec);
  assign bus3.s_in = (s_mode == 2'd1) ? 1'b1 : (s_mode == 2'd2) ? 1'b0 : func_s(bus3.vec);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic rd(input bit sel3, output logic [3:0] v, output logic b, output logic d,
                    output logic tv, output logic [15:0] t, output logic [4:0] o);
    if (sel3) begin
      v = bus3.vec; b = bus3.busy; d = bus3.done;
      tv = bus3.table_valid; t = bus3.table_o; o = bus3.ones_cnt;
    end else begin
      v = bus1.vec; b = bus1.busy; d = bus1.done;
      tv = bus1.table_valid; t = bus1.table_o; o = bus1.ones_cnt;
    end
  endtask

  task automatic set_start(input bit sel3, input logic val);
    if (sel3) bus3.start = val;
    else      bus1.start = val;
  endtask

  task automatic sb_compare(input logic [15:0] t, input logic [4:0] o);
    exp_t e;
    check("sb_depth", 32'(sb_q.size() > 0), 32'd1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("table_o", 32'(t), 32'(e.tab));
      check("ones_cnt", 32'(o), 32'(e.ones));
    end
  endtask

  // One start pulse, then track vec/busy every cycle until done and a few cycles past it.
  task automatic run_scan(input bit sel3, input int s, input bit extra_starts,
                          input logic [15:0] exp_tab, input logic [4:0] exp_ones);
    logic [3:0]  v;
    logic        b, d, tv;
    logic [15:0] t;
    logic [4:0]  o;
    int          lat;
    int          n_done;
    lat    = -1;
    n_done = 0;
    sb_q.push_back('{tab: exp_tab, ones: exp_ones});
    @(negedge clk);
    set_start(sel3, 1'b1);
    @(posedge clk);
    @(negedge clk);
    set_start(sel3, 1'b0);
    for (int n = 1; n <= 16 * s + 4; n++) begin
      @(negedge clk);
      rd(sel3, v, b, d, tv, t, o);
      if (d) begin
        n_done++;
        if (n_done == 1) begin
          lat = n;
          check("busy_at_done", 32'(b), 32'd0);
          check("valid_at_done", 32'(tv), 32'd1);
          check("vec_at_done", 32'(v), 32'd0);
          sb_compare(t, o);
        end
      end else if (n_done == 0) begin
        check("vec_hold", 32'(v), 32'(n / s));
        check("busy_scan", 32'(b), 32'd1);
      end
      if (extra_starts && (n == 4 || n == 9)) set_start(sel3, 1'b1);
      if (extra_starts && (n == 5 || n == 10)) set_start(sel3, 1'b0);
    end
    check("done_count", 32'(n_done), 32'd1);
    check("done_latency", 32'(lat), 32'(16 * s));
    rd(sel3, v, b, d, tv, t, o);
    check("valid_hold", 32'(tv), 32'd1);
    check("table_hold", 32'(t), 32'(exp_tab));
  endtask

  initial begin
    logic [3:0]  v;
    logic        b, d, tv;
    logic [15:0] t;
    logic [4:0]  o;
    int          n_done;
    int          t0, t1;

    rst_n      = 1'b0;
    s_mode     = 2'd0;
    bus1.start = 1'b0;
    bus3.start = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state on both instances.
    for (int i = 0; i < 2; i++) begin
      rd(i[0], v, b, d, tv, t, o);
      check("rst_vec", 32'(v), 32'd0);
      check("rst_busy", 32'(b), 32'd0);
      check("rst_done", 32'(d), 32'd0);
      check("rst_valid", 32'(tv), 32'd0);
      check("rst_table", 32'(t), 32'd0);
      check("rst_ones", 32'(o), 32'd0);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic scans at S=1 and S=3.
    run_scan(1'b0, 1, 1'b0, 16'hAC3C, 5'd8);
    run_scan(1'b1, 3, 1'b0, 16'hAC3C, 5'd8);

    // Starts during a scan are ignored.
    run_scan(1'b0, 1, 1'b1, 16'hAC3C, 5'd8);

    // Asynchronous reset just after edge 7 of a scan.
    @(negedge clk);
    bus1.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus1.start = 1'b0;
    repeat (7) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    rd(1'b0, v, b, d, tv, t, o);
    check("arst_vec", 32'(v), 32'd0);
    check("arst_busy", 32'(b), 32'd0);
    check("arst_table", 32'(t), 32'd0);
    check("arst_ones", 32'(o), 32'd0);
    check("arst_valid", 32'(tv), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    n_done = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bus1.done) n_done++;
    end
    check("arst_no_done", 32'(n_done), 32'd0);
    run_scan(1'b0, 1, 1'b0, 16'hAC3C, 5'd8);

    // Function output tied high, then low.
    s_mode = 2'd1;
    run_scan(1'b0, 1, 1'b0, 16'hFFFF, 5'd16);
    s_mode = 2'd2;
    run_scan(1'b0, 1, 1'b0, 16'h0000, 5'd0);
    s_mode = 2'd0;

    // Start held high: back-to-back scans.
    sb_q.push_back('{tab: 16'hAC3C, ones: 5'd8});
    sb_q.push_back('{tab: 16'hAC3C, ones: 5'd8});
    n_done = 0;
    t0     = -1;
    t1     = -1;
    @(negedge clk);
    bus1.start = 1'b1;
    for (int n = 0; n < 60 && n_done < 2; n++) begin
      @(negedge clk);
      rd(1'b0, v, b, d, tv, t, o);
      if (n_done == 1 && n == t0 + 1) check("b2b_valid_idle", 32'(tv), 32'd1);
      if (n_done == 1 && n == t0 + 2) begin
        check("b2b_valid_drop", 32'(tv), 32'd0);
        check("b2b_busy_restart", 32'(b), 32'd1);
      end
      if (d) begin
        if (n_done == 0) t0 = n;
        else             t1 = n;
        n_done++;
        sb_compare(t, o);
      end
    end
    bus1.start = 1'b0;
    check("b2b_first_done", 32'(t0), 32'd16);
    check("b2b_spacing", 32'(t1 - t0), 32'd18);
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    repeat (4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
